// File: rtl/usb_tx_sequencer_if.sv
// Packet-request, payload-FIFO, serializer and EOP signals between the USB TX sequencer and its surroundings.
// master = sequencer side, slave = the environment (FIFO, serializer, line driver, packet requester).
interface usb_tx_sequencer_if #(
    parameter int LEN_W = 7
);
    logic             tx_start;
    logic [3:0]       tx_pid;
    logic             tx_data_pkt;
    logic [LEN_W-1:0] tx_len;
    logic [7:0]       fifo_data;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [7:0]       ser_byte;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             eop_req;
    logic             eop_ack;
    logic             tx_busy;
    logic             tx_done;
    logic             tx_err;

    modport master (
        input  tx_start, tx_pid, tx_data_pkt, tx_len, fifo_data, fifo_empty, ser_ready, eop_ack,
        output fifo_rd_en, ser_byte, ser_valid, ser_last, eop_req, tx_busy, tx_done, tx_err
    );

    modport slave (
        output tx_start, tx_pid, tx_data_pkt, tx_len, fifo_data, fifo_empty, ser_ready, eop_ack,
        input  fifo_rd_en, ser_byte, ser_valid, ser_last, eop_req, tx_busy, tx_done, tx_err
    );
endinterface

// File: rtl/usb_tx_sequencer.sv
// Builds USB packets (SYNC, PID, payload, CRC16, EOP) from a FWFT FIFO into a byte serializer; SYNC is valid the cycle after tx_start.
// Backpressure: bytes hold while ser_ready=0, payload stalls while the FIFO is empty; one idle cycle between PID and first payload byte.
module usb_tx_sequencer #(
    parameter int MAX_PAYLOAD = 64,
    parameter int LEN_W       = 7
) (
    input logic                clk,
    input logic                rst,
    usb_tx_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP} state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

    state_t           state, state_nxt;
    logic [7:0]       ser_byte_q;
    logic             ser_valid_q, ser_last_q, done_q, err_q;
    logic [3:0]       pid_q;
    logic             data_pkt_q, clamp_q;
    logic [LEN_W-1:0] len_q, cnt;
    logic [15:0]      crc;
    logic             load, drop, pop, fin, load_last;
    logic [7:0]       load_byte;
    logic             xfer, can_load;
    logic [LEN_W-1:0] len_clamped;

    // Reflected USB CRC16 (0x8005 bit-reversed), payload bits consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    assign xfer        = ser_valid_q & bus.ser_ready;
    assign can_load    = ~ser_valid_q | bus.ser_ready;
    assign len_clamped = (bus.tx_len > MAX_LEN) ? MAX_LEN : bus.tx_len;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_byte = 8'h00;
        load_last = 1'b0;
        drop      = 1'b0;
        pop       = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: if (bus.tx_start) begin
                load = 1'b1; load_byte = 8'h80; state_nxt = SYNC;
            end
            SYNC: if (xfer) begin
                load = 1'b1; load_byte = {~pid_q, pid_q}; load_last = ~data_pkt_q; state_nxt = PID;
            end
            PID: if (xfer) begin
                if (!data_pkt_q) begin
                    drop = 1'b1; state_nxt = EOP;
                end else if (len_q == '0) begin
                    load = 1'b1; load_byte = ~crc[7:0]; state_nxt = CRC_LO;
                end else begin
                    drop = 1'b1; state_nxt = DATA;
                end
            end
            DATA: if (can_load) begin
                // crc already includes the final payload byte once cnt reaches len_q
                if (cnt == len_q) begin
                    load = 1'b1; load_byte = ~crc[7:0]; state_nxt = CRC_LO;
                end else if (!bus.fifo_empty) begin
                    load = 1'b1; load_byte = bus.fifo_data; pop = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            CRC_LO: if (xfer) begin
                load = 1'b1; load_byte = ~crc[15:8]; load_last = 1'b1; state_nxt = CRC_HI;
            end
            CRC_HI: if (xfer) begin
                drop = 1'b1; state_nxt = EOP;
            end
            EOP: if (bus.eop_ack) begin
                fin = 1'b1; state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ser_byte_q  <= 8'h00;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            pid_q       <= 4'h0;
            data_pkt_q  <= 1'b0;
            clamp_q     <= 1'b0;
            len_q       <= '0;
            cnt         <= '0;
            crc         <= 16'hFFFF;
        end else begin
            done_q <= fin;
            err_q  <= fin & clamp_q;
            if (load) begin
                ser_byte_q  <= load_byte;
                ser_valid_q <= 1'b1;
                ser_last_q  <= load_last;
            end else if (drop) begin
                ser_valid_q <= 1'b0;
                ser_last_q  <= 1'b0;
            end
            if (state == IDLE && bus.tx_start) begin
                pid_q      <= bus.tx_pid;
                data_pkt_q <= bus.tx_data_pkt;
                len_q      <= len_clamped;
                clamp_q    <= bus.tx_data_pkt & (bus.tx_len > MAX_LEN);
                cnt        <= '0;
                crc        <= 16'hFFFF;
            end else if (pop) begin
                cnt <= cnt + LEN_W'(1);
                crc <= crc16_byte(crc, bus.fifo_data);
            end
        end
    end

    // The pop strobe is gated by rst so a reset mid-payload never consumes a FIFO byte.
    assign bus.fifo_rd_en = pop & ~rst;
    assign bus.ser_byte   = ser_byte_q;
    assign bus.ser_valid  = ser_valid_q;
    assign bus.ser_last   = ser_last_q;
    assign bus.eop_req    = (state == EOP);
    assign bus.tx_busy    = (state != IDLE);
    assign bus.tx_done    = done_q;
    assign bus.tx_err     = err_q;
endmodule
